// File: rtl/ahb_reg_bridge.sv
// rtl/ahb_reg_bridge.sv - AHB-Lite slave to single-cycle register request bridge (optional RW_AHB_SIZE_ERR_EN)
// Writes are posted; reads stall the bus until the register side returns data.
module ahb_reg_bridge #(
    parameter int REG_ADDR_WIDTH = 15,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      macPIClk,
    input  logic                      macPIClkHardRst_n,
    input  logic                      hSel,
    input  logic [REG_ADDR_WIDTH+1:0] hAddr,
    input  logic [1:0]                hTrans,
    input  logic                      hWrite,
    input  logic [2:0]                hSize,
    input  logic [DATA_WIDTH-1:0]     hWData,
    input  logic                      hReadyIn,
    output logic                      hReadyOut,
    output logic                      hResp,
    output logic [DATA_WIDTH-1:0]     hRData,
    output logic                      regSel,
    output logic                      regWrite,
    output logic                      regRead,
    output logic [REG_ADDR_WIDTH-1:0] regAddr,
    output logic [DATA_WIDTH-1:0]     regWriteData,
    input  logic                      regReadyIn,
    input  logic [DATA_WIDTH-1:0]     regReadData
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, RD_ISSUE, RD_WAIT, RD_DONE, ERR1, ERR2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    state_t                    accept_state;
    logic                      pending;
    logic                      busy;
    logic                      accept;
    logic                      accept_err;
    logic                      issue_wr;
    logic                      issue_rd;
    logic                      capture_rd;
    logic [REG_ADDR_WIDTH-1:0] addr_q;

    // A request is outstanding from the pulse until the downstream reports idle again.
    assign busy   = regSel | pending;
    assign accept = hSel & hTrans[1] & hReadyIn & hReadyOut;

`ifdef RW_AHB_SIZE_ERR_EN
    assign accept_err = (hSize != 3'b010) || (hAddr[1:0] != 2'b00);
`else
    logic unused_size_bits;
    assign unused_size_bits = ^{hSize, hAddr[1:0]};
    assign accept_err       = 1'b0;
`endif

    always_comb begin
        if (accept_err)
            accept_state = ERR1;
        else if (hWrite)
            accept_state = WR_DATA;
        else
            accept_state = RD_ISSUE;
    end

    always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
        if (!macPIClkHardRst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = accept_state;
            WR_DATA:  if (!busy) state_next = accept ? accept_state : IDLE;
            RD_ISSUE: if (!busy) state_next = RD_WAIT;
            RD_WAIT:  if (capture_rd) state_next = RD_DONE;
            RD_DONE:  state_next = accept ? accept_state : IDLE;
`ifdef RW_AHB_SIZE_ERR_EN
            ERR1:     state_next = ERR2;
            ERR2:     state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        hReadyOut  = 1'b1;
        hResp      = 1'b0;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        capture_rd = 1'b0;
        case (state)
            WR_DATA: begin
                hReadyOut = !busy;
                issue_wr  = !busy;
            end
            RD_ISSUE: begin
                hReadyOut = 1'b0;
                issue_rd  = !busy;
            end
            RD_WAIT: begin
                hReadyOut  = 1'b0;
                // pending only rises after our own pulse, so ready here is the read's completion
                capture_rd = pending & regReadyIn & !regSel;
            end
`ifdef RW_AHB_SIZE_ERR_EN
            ERR1: begin
                hReadyOut = 1'b0;
                hResp     = 1'b1;
            end
            ERR2: begin
                hResp = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
        if (!macPIClkHardRst_n) begin
            regSel       <= 1'b0;
            regWrite     <= 1'b0;
            regRead      <= 1'b0;
            regAddr      <= '0;
            regWriteData <= '0;
            hRData       <= '0;
            pending      <= 1'b0;
            addr_q       <= '0;
        end else begin
            regSel   <= issue_wr | issue_rd;
            regWrite <= issue_wr;
            regRead  <= issue_rd;
            if (issue_wr | issue_rd)
                regAddr <= addr_q;
            if (issue_wr)
                regWriteData <= hWData;
            if (capture_rd)
                hRData <= regReadData;
            if (regSel)
                pending <= 1'b1;
            else if (regReadyIn)
                pending <= 1'b0;
            if (accept)
                addr_q <= hAddr[REG_ADDR_WIDTH+1:2];
        end
    end

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// tb/tb_ahb_reg_bridge.sv - scoreboard bench for ahb_reg_bridge (honours RW_AHB_SIZE_ERR_EN)
module tb_ahb_reg_bridge;

    localparam int AW = 15;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hSel;
    logic [AW+1:0] hAddr;
    logic [1:0]    hTrans;
    logic          hWrite;
    logic [2:0]    hSize;
    logic [DW-1:0] hWData;
    logic          hReadyOut;
    logic          hResp;
    logic [DW-1:0] hRData;
    logic          regSel;
    logic          regWrite;
    logic          regRead;
    logic [AW-1:0] regAddr;
    logic [DW-1:0] regWriteData;
    logic          regReadyIn;
    logic [DW-1:0] regReadData;

    always #5 clk = ~clk;

    ahb_reg_bridge #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .macPIClk          (clk),
        .macPIClkHardRst_n (rst_n),
        .hSel              (hSel),
        .hAddr             (hAddr),
        .hTrans            (hTrans),
        .hWrite            (hWrite),
        .hSize             (hSize),
        .hWData            (hWData),
        .hReadyIn          (hReadyOut),
        .hReadyOut         (hReadyOut),
        .hResp             (hResp),
        .hRData            (hRData),
        .regSel            (regSel),
        .regWrite          (regWrite),
        .regRead           (regRead),
        .regAddr           (regAddr),
        .regWriteData      (regWriteData),
        .regReadyIn        (regReadyIn),
        .regReadData       (regReadData)
    );

    typedef struct packed {
        logic          wr;
        logic          err;
        logic [AW+1:0] addr;
        logic [2:0]    size;
        logic [DW-1:0] data;
        int            exp_waits;
    } xfer_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pulse_t;

    xfer_t         txq[$];
    pulse_t        pq[$];
    logic [DW-1:0] rexpq[$];
    logic [DW-1:0] shadow[int];
    logic [DW-1:0] ds_mem[int];
    int            ds_lat = 6;
    int            ds_cnt;
    logic          prev_sel;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Downstream register stage: ready drops for ds_lat cycles after each pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regReadyIn <= 1'b1;
            ds_cnt     <= 0;
        end else if (regSel) begin
            regReadyIn <= 1'b0;
            ds_cnt     <= ds_lat - 1;
            if (regWrite)
                ds_mem[int'(regAddr)] = regWriteData;
            if (regRead)
                regReadData <= ds_mem.exists(int'(regAddr)) ? ds_mem[int'(regAddr)] : '0;
        end else if (ds_cnt > 0) begin
            ds_cnt <= ds_cnt - 1;
        end else begin
            regReadyIn <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (regSel) begin
                chk("pulse_single_cycle", prev_sel, 1'b0);
                chk("downstream_idle_at_pulse", regReadyIn, 1'b1);
                chk("pulse_onehot", regWrite ^ regRead, 1'b1);
                if (pq.size() == 0) begin
                    chk("unexpected_pulse", 1'b1, 1'b0);
                end else begin
                    pulse_t p;
                    p = pq.pop_front();
                    chk("pulse_is_write", regWrite, p.wr);
                    chk("pulse_addr", regAddr, p.addr);
                    if (p.wr)
                        chk("pulse_wdata", regWriteData, p.data);
                end
            end else if (regWrite || regRead) begin
                chk("strobe_without_sel", {regWrite, regRead}, 2'b00);
            end
        end
        prev_sel <= regSel;
    end

    function automatic xfer_t mk(input logic wr, input logic [AW+1:0] addr, input logic [2:0] size,
                                 input logic [DW-1:0] data, input int exp_waits);
        xfer_t t;
        t.wr        = wr;
        t.addr      = addr;
        t.size      = size;
        t.data      = data;
        t.exp_waits = exp_waits;
`ifdef RW_AHB_SIZE_ERR_EN
        t.err = (size != 3'b010) || (addr[1:0] != 2'b00);
`else
        t.err = 1'b0;
`endif
        return t;
    endfunction

    task automatic on_accept(input xfer_t t);
        pulse_t p;
        int     wa;
        if (!t.err) begin
            wa     = int'(t.addr[AW+1:2]);
            p.wr   = t.wr;
            p.addr = t.addr[AW+1:2];
            p.data = t.wr ? t.data : '0;
            pq.push_back(p);
            if (t.wr)
                shadow[wa] = t.data;
            else
                rexpq.push_back(shadow.exists(wa) ? shadow[wa] : '0);
        end
    endtask

    task automatic idle_cycles(input int n);
        hSel   = 1'b0;
        hTrans = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pipelined AHB master: the address phase of the next transfer overlaps the current data phase.
    task automatic run_bus();
        xfer_t cur;
        logic  have_dp = 1'b0;
        logic  drv;
        logic  rdy;
        int    waits = 0;
        int    guard = 0;
        cur = '0;
        while ((txq.size() > 0 || have_dp) && guard < 400) begin
            drv = (txq.size() > 0);
            if (drv) begin
                hSel   = 1'b1;
                hTrans = 2'b10;
                hWrite = txq[0].wr;
                hAddr  = txq[0].addr;
                hSize  = txq[0].size;
            end else begin
                hSel   = 1'b0;
                hTrans = 2'b00;
            end
            hWData = (have_dp && cur.wr) ? cur.data : '0;
            @(negedge clk);
            rdy = hReadyOut;
            if (have_dp) begin
                if (cur.err) begin
                    chk(waits == 0 ? "err1_resp" : "err2_resp", hResp, 1'b1);
                    chk(waits == 0 ? "err1_ready" : "err2_ready", rdy, waits != 0);
                end else if (rdy) begin
                    chk("resp_okay", hResp, 1'b0);
                    if (cur.exp_waits >= 0)
                        chk(cur.wr ? "write_wait_states" : "read_wait_states", waits, cur.exp_waits);
                    if (!cur.wr) begin
                        if (rexpq.size() == 0)
                            chk("read_expectation_missing", 1'b1, 1'b0);
                        else
                            chk("read_data", hRData, rexpq.pop_front());
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                have_dp = 1'b0;
                waits   = 0;
                if (drv) begin
                    cur = txq.pop_front();
                    on_accept(cur);
                    have_dp = 1'b1;
                end
            end else begin
                waits++;
            end
            guard++;
        end
        if (guard >= 400)
            chk("bus_timeout", 1'b1, 1'b0);
        hSel   = 1'b0;
        hTrans = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        hSel   = 1'b0;
        hAddr  = '0;
        hTrans = 2'b00;
        hWrite = 1'b0;
        hSize  = 3'b010;
        hWData = '0;
        ds_mem[8] = 32'h1234_5678;
        shadow[8] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", hReadyOut, 1'b1);
        chk("rst_hresp", hResp, 1'b0);
        chk("rst_hrdata", hRData, '0);
        chk("rst_reg_strobes", {regSel, regWrite, regRead}, 3'b000);
        chk("rst_reg_addr", regAddr, '0);
        chk("rst_reg_wdata", regWriteData, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(10);
        @(negedge clk);
        chk("idle_hready", hReadyOut, 1'b1);
        chk("idle_no_pulse", {regSel, regWrite, regRead}, 3'b000);
        @(posedge clk);
        #1;

        ds_lat = 6;
        txq.push_back(mk(1'b1, 17'h0010, 3'b010, 32'hDEAD_BEEF, 0));
        run_bus();
        idle_cycles(12);

        txq.push_back(mk(1'b1, 17'h0000, 3'b010, 32'h1111_1111, 0));
        txq.push_back(mk(1'b1, 17'h0004, 3'b010, 32'hA5A5_A5A5, ds_lat + 2));
        run_bus();
        idle_cycles(12);

        ds_lat = 5;
        txq.push_back(mk(1'b0, 17'h0020, 3'b010, '0, ds_lat + 3));
        run_bus();
        idle_cycles(12);

        ds_lat = 6;
        txq.push_back(mk(1'b1, 17'h0040, 3'b010, 32'hCAFE_F00D, 0));
        txq.push_back(mk(1'b0, 17'h0040, 3'b010, '0, 2 * ds_lat + 5));
        run_bus();
        idle_cycles(12);

        txq.push_back(mk(1'b0, 17'h0010, 3'b010, '0, ds_lat + 3));
        txq.push_back(mk(1'b1, 17'h0044, 3'b010, 32'h5555_AAAA, 0));
        txq.push_back(mk(1'b0, 17'h0044, 3'b010, '0, 2 * ds_lat + 5));
        txq.push_back(mk(1'b0, 17'h0004, 3'b010, '0, -1));
        run_bus();
        idle_cycles(12);

        txq.push_back(mk(1'b1, 17'h0003, 3'b000, 32'h0000_0077, 0));
        run_bus();
        idle_cycles(12);

        txq.push_back(mk(1'b0, 17'h0000, 3'b010, '0, ds_lat + 3));
        run_bus();
        idle_cycles(12);

        chk("pulse_queue_drained", pq.size(), 0);
        chk("read_queue_drained", rexpq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
